texture_fetch: RTL and testbench

TEXTURE_FETCH -- requirements
Module: texture_fetch

---
 rtl/texture_fetch_pkg.sv | 41 ++++
 rtl/texture_fetch.sv | 136 +++++++++++++
 tb/tb_texture_fetch.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/texture_fetch_pkg.sv
// Shared constants, state encoding and helpers for the texture fetch unit.
// The RGB slice macro lives here so every file that imports the package
// extracts colour bits from a received flash byte the same way.

`ifndef TEXTURE_FETCH_HELPERS
`define TEXTURE_FETCH_HELPERS
`define RGB(byte_val) byte_val[5:0]
`endif

package texture_fetch_pkg;

  localparam logic [7:0] CMD_READ_DEFAULT = 8'h03;

  localparam int OPCODE_BITS = 8;
  localparam int ADDR_BITS   = 24;
  localparam int DATA_BITS   = 8;
  localparam int TOTAL_BITS  = OPCODE_BITS + ADDR_BITS + DATA_BITS;

  // Each SPI bit takes two clk phases, so the counter runs 0..79.
  localparam int PHASE_LAST     = 2 * TOTAL_BITS - 1;
  localparam int DATA_BIT_START = OPCODE_BITS + ADDR_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  // Texel offset within the texture space, zero-extended to the flash address width.
  function automatic logic [23:0] texel_offset(
    input logic [1:0] wall,
    input logic [5:0] u,
    input logic [5:0] v,
    input int         shift
  );
    logic [23:0] off;
    off = {10'd0, wall, u, v};
    return off << shift;
  endfunction

endpackage

// File: rtl/texture_fetch.sv
// Texel fetch engine: turns a (wall, u, v) request into an SPI flash read
// (opcode, 24-bit address, one data byte) and returns the 6-bit colour.

module texture_fetch
  import texture_fetch_pkg::*;
#(
  parameter logic [7:0] CMD_READ  = CMD_READ_DEFAULT,
  parameter int         TEX_SHIFT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  output logic        ready,
  input  logic [1:0]  wall_id,
  input  logic [5:0]  texu,
  input  logic [5:0]  texv,
  input  logic [23:0] texadd0,
  input  logic [23:0] texadd1,
  input  logic [23:0] texadd2,
  input  logic [23:0] texadd3,
  output logic        valid,
  output logic [5:0]  texel,
  output logic        o_spi_sclk,
  output logic        o_spi_cs_n,
  output logic        o_spi_mosi,
  input  logic        i_spi_miso
);

  state_t      state;
  state_t      next_state;
  logic [6:0]  phase_cnt;
  logic [5:0]  bit_idx;
  logic [31:0] tx_shift;
  logic [7:0]  rx_shift;
  logic [7:0]  rx_next;
  logic [23:0] texadd_sel;
  logic [23:0] tex_offset;
  logic [23:0] fetch_addr;
  logic [5:0]  texel_q;
  logic        accept;
  logic        high_phase;
  logic        phase_last;
  logic        data_phase;
  logic        unused_rx_msb;

  // Pick the live addend for the requested wall; it is only sampled on accept.
  always_comb begin
    texadd_sel = texadd0;
    case (wall_id)
      2'd0: texadd_sel = texadd0;
      2'd1: texadd_sel = texadd1;
      2'd2: texadd_sel = texadd2;
      2'd3: texadd_sel = texadd3;
      default: texadd_sel = texadd0;
    endcase
  end

  assign tex_offset = texel_offset(wall_id, texu, texv, TEX_SHIFT);
  assign fetch_addr = texadd_sel + tex_offset;

  assign accept     = (state == IDLE) && req;
  assign bit_idx    = phase_cnt[6:1];
  assign high_phase = phase_cnt[0];
  assign phase_last = (phase_cnt == 7'(PHASE_LAST));
  assign data_phase = (bit_idx >= 6'(DATA_BIT_START));
  assign rx_next    = {rx_shift[6:0], i_spi_miso};

  // The colour byte's top bit never reaches texel; naming it marks the drop as deliberate.
  assign unused_rx_msb = rx_shift[7];

  // State register; reset from any state returns straight to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: one full 80-phase transfer, then a single DONE cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req)        next_state = XFER;
      XFER:    if (phase_last) next_state = DONE;
      DONE:                    next_state = IDLE;
      default:                 next_state = IDLE;
    endcase
  end

  // Outputs decoded from state; sclk and mosi are forced quiet outside XFER.
  always_comb begin
    ready      = 1'b0;
    valid      = 1'b0;
    o_spi_cs_n = 1'b1;
    o_spi_sclk = 1'b0;
    o_spi_mosi = 1'b0;
    case (state)
      IDLE: ready = 1'b1;
      XFER: begin
        o_spi_cs_n = 1'b0;
        o_spi_sclk = high_phase;
        o_spi_mosi = !data_phase && tx_shift[31];
      end
      DONE: valid = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  // SPI shifter: load command+address on accept, shift out after each high phase, shift in data bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_cnt <= 7'd0;
      tx_shift  <= 32'd0;
      rx_shift  <= 8'd0;
      texel_q   <= 6'd0;
    end else if (accept) begin
      phase_cnt <= 7'd0;
      tx_shift  <= {CMD_READ, fetch_addr};
    end else if (state == XFER) begin
      phase_cnt <= phase_last ? 7'd0 : phase_cnt + 7'd1;
      if (high_phase) begin
        tx_shift <= {tx_shift[30:0], 1'b0};
        if (data_phase) begin
          rx_shift <= rx_next;
        end
      end
      if (phase_last) begin
        texel_q <= `RGB(rx_next);
      end
    end
  end

  assign texel = texel_q;

endmodule

// File: tb/tb_texture_fetch.sv
// Directed bench for texture_fetch with a mode-0 SPI flash model.

module tb_texture_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        ready;
  logic [1:0]  wall_id;
  logic [5:0]  texu;
  logic [5:0]  texv;
  logic [23:0] texadd0, texadd1, texadd2, texadd3;
  logic        valid;
  logic [5:0]  texel;
  logic        o_spi_sclk;
  logic        o_spi_cs_n;
  logic        o_spi_mosi;
  logic        i_spi_miso;

  int checkCount = 0;
  int errorCount = 0;

  texture_fetch dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .ready      (ready),
    .wall_id    (wall_id),
    .texu       (texu),
    .texv       (texv),
    .texadd0    (texadd0),
    .texadd1    (texadd1),
    .texadd2    (texadd2),
    .texadd3    (texadd3),
    .valid      (valid),
    .texel      (texel),
    .o_spi_sclk (o_spi_sclk),
    .o_spi_cs_n (o_spi_cs_n),
    .o_spi_mosi (o_spi_mosi),
    .i_spi_miso (i_spi_miso)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Global watchdog so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Cycle counter used by the monitors
  int cycleCount = 0;
  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Flash model (mode 0): captures MOSI on sclk rise, shifts MISO on sclk fall
  logic [7:0]  flashByte = 8'h00;
  logic [31:0] mosiWord  = 32'd0;
  logic [7:0]  mosiData  = 8'd0;
  int fallCnt = 0;
  int riseCnt = 0;
  int lastRise = 0;
  bit prevRiseValid = 0;
  int widthErr = 0;

  always @(negedge o_spi_cs_n) begin
    fallCnt = 0;
    riseCnt = 0;
    mosiWord = 32'd0;
    mosiData = 8'd0;
    prevRiseValid = 0;
  end

  always @(posedge o_spi_sclk) begin
    if (!o_spi_cs_n) begin
      if (riseCnt < 32) mosiWord = {mosiWord[30:0], o_spi_mosi};
      else if (riseCnt < 40) mosiData = {mosiData[6:0], o_spi_mosi};
      riseCnt++;
    end
    if (prevRiseValid && (cycleCount - lastRise) != 2) widthErr++;
    lastRise = cycleCount;
    prevRiseValid = 1;
  end

  always @(negedge o_spi_sclk) begin
    fallCnt++;
    if ((cycleCount - lastRise) != 1) widthErr++;
  end

  assign i_spi_miso = (!o_spi_cs_n && fallCnt >= 32 && fallCnt < 40) ? flashByte[3'(39 - fallCnt)] : 1'b0;

  // Bus monitors: sclk activity with cs_n high, valid pulses, accepts, idle gaps
  int sclkViol = 0;
  int validCount = 0;
  int gapRun = 0;
  int minGap = 1000;
  bit gapArmed = 0;
  bit burstOn = 0;
  always @(negedge clk) begin
    if (o_spi_cs_n && o_spi_sclk) sclkViol++;
    if (valid) validCount++;
    if (o_spi_cs_n) begin
      gapRun++;
    end else begin
      if (gapArmed && gapRun > 0 && gapRun < minGap) minGap = gapRun;
      gapRun = 0;
      gapArmed = burstOn;
    end
  end

  int acceptCycle [0:31];
  int acceptN = 0;
  always @(posedge clk) begin
    if (!reset && ready && req && acceptN < 32) begin
      acceptCycle[acceptN] <= cycleCount;
      acceptN <= acceptN + 1;
    end
  end

  // One fetch: wait for ready, request, then count cycles until valid
  task automatic applyStimulus(input logic [1:0] w, input logic [5:0] u, input logic [5:0] v,
                               input logic [7:0] b, input logic [5:0] prevTexel,
                               input bit changeAdd0, output int latency);
    latency = -1;
    for (int i = 0; i < 200 && !ready; i++) @(negedge clk);
    if (!ready) begin
      checkOutput("ready before request", {31'd0, ready}, 32'd1);
      return;
    end
    @(negedge clk);
    wall_id = w;
    texu = u;
    texv = v;
    flashByte = b;
    req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    if (changeAdd0) texadd0 = 24'h123456;
    latency = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      latency++;
      if (latency == 40) checkOutput("texel held during transfer", {26'd0, texel}, {26'd0, prevTexel});
      if (valid) break;
    end
    if (!valid) latency = -1;
  endtask

  int lat;
  int startIdx;
  int vcSnap;

  initial begin
    reset = 1'b1;
    req = 1'b0;
    wall_id = 2'd0;
    texu = 6'd0;
    texv = 6'd0;
    texadd0 = 24'd0;
    texadd1 = 24'h001000;
    texadd2 = 24'd0;
    texadd3 = 24'hFFFFFF;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset ready", {31'd0, ready}, 32'd1);
    checkOutput("reset valid", {31'd0, valid}, 32'd0);
    checkOutput("reset texel", {26'd0, texel}, 32'd0);
    checkOutput("reset cs_n", {31'd0, o_spi_cs_n}, 32'd1);
    checkOutput("reset sclk", {31'd0, o_spi_sclk}, 32'd0);
    checkOutput("reset mosi", {31'd0, o_spi_mosi}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Fetch A: 0x001000 + {01,000010,000011}=0x1083 -> 0x002083, byte E5 -> texel 25
    applyStimulus(2'd1, 6'd2, 6'd3, 8'hE5, 6'h00, 0, lat);
    checkOutput("A latency", lat, 32'd80);
    checkOutput("A mosi", mosiWord, 32'h03002083);
    checkOutput("A mosi data bits", {24'd0, mosiData}, 32'd0);
    checkOutput("A texel", {26'd0, texel}, 32'h25);
    checkOutput("A cs_n in DONE", {31'd0, o_spi_cs_n}, 32'd1);
    checkOutput("A ready in DONE", {31'd0, ready}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("A valid one cycle", {31'd0, valid}, 32'd0);
    checkOutput("A ready after valid", {31'd0, ready}, 32'd1);
    checkOutput("A texel hold", {26'd0, texel}, 32'h25);

    // Fetch B: 0xFFFFFF + 0x3001 wraps to 0x003000
    applyStimulus(2'd3, 6'd0, 6'd1, 8'h3F, 6'h25, 0, lat);
    checkOutput("B latency", lat, 32'd80);
    checkOutput("B mosi wrap", mosiWord, 32'h03003000);
    checkOutput("B texel", {26'd0, texel}, 32'h3F);

    // Fetch C: 0x000100 + 0x147 = 0x000247, texadd0 changed after accept
    texadd0 = 24'h000100;
    applyStimulus(2'd0, 6'd5, 6'd7, 8'hC0, 6'h3F, 1, lat);
    checkOutput("C latency", lat, 32'd80);
    checkOutput("C mosi latched addr", mosiWord, 32'h03000247);
    checkOutput("C texel", {26'd0, texel}, 32'h00);

    // Burst: req held high for 250 edges -> accepts at edges 1, 83, 165, 247
    for (int i = 0; i < 200 && !ready; i++) @(negedge clk);
    @(negedge clk);
    wall_id = 2'd1;
    texu = 6'd2;
    texv = 6'd3;
    flashByte = 8'h2A;
    startIdx = acceptN;
    vcSnap = validCount;
    burstOn = 1;
    req = 1'b1;
    repeat (250) @(posedge clk);
    #1;
    req = 1'b0;
    burstOn = 0;
    for (int i = 0; i < 200 && !valid; i++) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    checkOutput("burst accept count", acceptN - startIdx, 32'd4);
    for (int k = 0; k < 3; k++)
      checkOutput("burst accept period", acceptCycle[startIdx + k + 1] - acceptCycle[startIdx + k], 32'd82);
    checkOutput("burst cs_n gap", minGap, 32'd2);
    checkOutput("burst valid count", validCount - vcSnap, 32'd4);
    checkOutput("burst texel", {26'd0, texel}, 32'h2A);

    // Reset mid-transfer at phase count 40
    for (int i = 0; i < 200 && !ready; i++) @(negedge clk);
    @(negedge clk);
    flashByte = 8'hFF;
    req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    checkOutput("abort cs_n before reset", {31'd0, o_spi_cs_n}, 32'd0);
    reset = 1'b1;
    vcSnap = validCount;
    @(posedge clk);
    #1;
    checkOutput("abort cs_n", {31'd0, o_spi_cs_n}, 32'd1);
    checkOutput("abort sclk", {31'd0, o_spi_sclk}, 32'd0);
    checkOutput("abort ready", {31'd0, ready}, 32'd1);
    checkOutput("abort valid", {31'd0, valid}, 32'd0);
    checkOutput("abort texel", {26'd0, texel}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    checkOutput("abort no valid", validCount - vcSnap, 32'd0);

    // Protocol monitors over the whole run
    checkOutput("sclk while cs_n high", sclkViol, 32'd0);
    checkOutput("sclk bit width", widthErr, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
